// File: rtl/rl_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rl_ram_pkg
// Description : Shared types and helpers for the rl_ram_1r1w_be RAM wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
package rl_ram_pkg;

    localparam int c_max_dbits = 512;
    localparam int c_max_nb    = c_max_dbits / 8;
    localparam int c_dbits_aw  = $clog2(c_max_dbits);
    localparam int c_nb_aw     = $clog2(c_max_nb);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    function automatic int nb_lanes(input int dbits);
        return (dbits + 7) / 8;
    endfunction

    // Bits above dbits stay zero, so a partial top lane only covers its valid bits.
    function automatic logic [c_max_dbits-1:0] lane_mask(input logic [c_max_nb-1:0] be,
                                                         input int dbits);
        logic [c_max_dbits-1:0] m;
        m = '0;
        for (int i = 0; i < c_max_dbits; i++) begin
            if (i < dbits) m[c_dbits_aw'(i)] = be[c_nb_aw'(i / 8)];
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rl_ram_1r1w_be_if.sv
`default_nettype none
// ============================================================================
// Module      : rl_ram_1r1w_be_if
// Description : Write/read port bundle of the byte-enable 1R1W RAM wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
interface rl_ram_1r1w_be_if
    import rl_ram_pkg::*;
#(
    parameter int ABITS = 10,
    parameter int DBITS = 32,
    parameter int NB    = nb_lanes(DBITS)
);
    logic [ABITS-1:0] waddr;
    logic [DBITS-1:0] din;
    logic             we;
    logic [NB-1:0]    be;
    logic [ABITS-1:0] raddr;
    logic             re;
    logic [DBITS-1:0] dout;
    logic             ready;
    logic             clr;

    modport master (output waddr, din, we, be, raddr, re, clr, input dout, ready);
    modport slave  (input waddr, din, we, be, raddr, re, clr, output dout, ready);
endinterface
`default_nettype wire

// File: rtl/rl_ram_1r1w.sv
`default_nettype none
// ============================================================================
// Module      : rl_ram_1r1w
// Description : Read-first 1R1W memory core with bit-masked writes.
// Revision    : 1.0 - initial release
// ============================================================================
module rl_ram_1r1w #(
    parameter int    ABITS      = 10,
    parameter int    DBITS      = 32,
    parameter int    DEPTH      = 2**ABITS,
    parameter string TECHNOLOGY = "GENERIC"
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic             i_flush,
    input  wire logic             i_we,
    input  wire logic [ABITS-1:0] i_waddr,
    input  wire logic [DBITS-1:0] i_wdata,
    input  wire logic [DBITS-1:0] i_wmask,
    input  wire logic             i_re,
    input  wire logic             i_rd_ok,
    input  wire logic [ABITS-1:0] i_raddr,
    output logic      [DBITS-1:0] o_rdata
);
    logic [DBITS-1:0] r_rdata;

    generate
        if (TECHNOLOGY == "GENERIC") begin : g_generic
            logic [DBITS-1:0] r_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (i_we) r_mem[i_waddr] <= (r_mem[i_waddr] & ~i_wmask) | (i_wdata & i_wmask);
            end

            // Out-of-range reads load zero instead of touching the array.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)        r_rdata <= '0;
                else if (i_flush) r_rdata <= '0;
                else if (i_re)    r_rdata <= i_rd_ok ? r_mem[i_raddr] : '0;
            end
        end else begin : g_unsupported_tech
            $error("rl_ram_1r1w: unsupported TECHNOLOGY");
            assign r_rdata = '0;
        end
    endgenerate

    assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/rl_ram_be_merge.sv
`default_nettype none
// ============================================================================
// Module      : rl_ram_be_merge
// Description : Captures a same-address write beside the read and merges lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module rl_ram_be_merge
    import rl_ram_pkg::*;
#(
    parameter int DBITS = 32,
    parameter int NB    = nb_lanes(DBITS)
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic             i_flush,
    input  wire logic             i_capture,
    input  wire logic             i_hit,
    input  wire logic [DBITS-1:0] i_wdata,
    input  wire logic [NB-1:0]    i_be,
    input  wire logic [DBITS-1:0] i_rdata,
    output logic      [DBITS-1:0] o_data
);
    logic             r_hit;
    logic [DBITS-1:0] r_din;
    logic [NB-1:0]    r_be;
    logic [DBITS-1:0] w_mask;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hit <= 1'b0;
            r_din <= '0;
            r_be  <= '0;
        end else if (i_flush) begin
            r_hit <= 1'b0;
            r_din <= '0;
            r_be  <= '0;
        end else if (i_capture) begin
            r_hit <= i_hit;
            r_din <= i_wdata;
            r_be  <= i_be;
        end
    end

    assign w_mask = DBITS'(lane_mask(c_max_nb'(r_be), DBITS)) & {DBITS{r_hit}};
    assign o_data = (i_rdata & ~w_mask) | (r_din & w_mask);
endmodule
`default_nettype wire

// File: rtl/rl_ram_1r1w_be.sv
`default_nettype none
// ============================================================================
// Module      : rl_ram_1r1w_be
// Description : Byte-enable 1R1W RAM wrapper with per-lane contention bypass.
//               Define RL_RAM_CLEAR_EN for the post-reset memory-clear sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module rl_ram_1r1w_be
    import rl_ram_pkg::*;
#(
    parameter int    ABITS      = 10,
    parameter int    DBITS      = 32,
    parameter int    DEPTH      = 2**ABITS,
    parameter int    RD_LATENCY = 1,
    parameter string TECHNOLOGY = "GENERIC"
) (
    input  wire logic          clk,
    input  wire logic          rstn,
    rl_ram_1r1w_be_if.slave    bus
);
    localparam int c_nb = nb_lanes(DBITS);

    logic             w_ready, w_flush, w_clr_req;
    logic             w_acc_we, w_acc_re, w_waddr_ok, w_raddr_ok, w_hit;
    logic             w_core_we;
    logic [ABITS-1:0] w_core_waddr;
    logic [DBITS-1:0] w_core_wdata, w_core_wmask, w_bus_mask, w_rdata, w_merged;

    generate
        if (DEPTH < 2**ABITS) begin : g_range_check
            assign w_waddr_ok = bus.waddr < ABITS'(DEPTH);
            assign w_raddr_ok = bus.raddr < ABITS'(DEPTH);
        end else begin : g_full_range
            assign w_waddr_ok = 1'b1;
            assign w_raddr_ok = 1'b1;
        end
    endgenerate

    assign w_bus_mask = DBITS'(lane_mask(c_max_nb'(bus.be), DBITS));
    assign w_acc_we   = bus.we & w_ready & w_waddr_ok;
    assign w_acc_re   = bus.re & w_ready & ~w_clr_req;
    assign w_hit      = w_acc_re & w_acc_we & w_raddr_ok & (bus.raddr == bus.waddr);

`ifdef RL_RAM_CLEAR_EN
    localparam logic [ABITS-1:0] c_last = ABITS'(DEPTH - 1);

    clr_state_e       r_state;
    logic [ABITS-1:0] r_cnt;
    logic             w_clearing;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (bus.clr) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_last) begin
                        r_state <= READY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                READY: begin
                    if (bus.clr) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= CLEAR;
            endcase
        end
    end

    assign w_clearing   = (r_state == CLEAR);
    assign w_ready      = (r_state == READY);
    assign w_clr_req    = bus.clr;
    // Holding the read path in flush keeps dout at zero for the whole clear.
    assign w_flush      = w_clearing | bus.clr;
    assign w_core_we    = w_clearing | w_acc_we;
    assign w_core_waddr = w_clearing ? r_cnt : bus.waddr;
    assign w_core_wdata = w_clearing ? '0 : bus.din;
    assign w_core_wmask = w_clearing ? '1 : w_bus_mask;
`else
    logic w_unused_clr;

    assign w_unused_clr = bus.clr;
    assign w_ready      = 1'b1;
    assign w_clr_req    = 1'b0;
    assign w_flush      = 1'b0;
    assign w_core_we    = w_acc_we;
    assign w_core_waddr = bus.waddr;
    assign w_core_wdata = bus.din;
    assign w_core_wmask = w_bus_mask;
`endif

    assign bus.ready = w_ready;

    rl_ram_1r1w #(
        .ABITS      (ABITS),
        .DBITS      (DBITS),
        .DEPTH      (DEPTH),
        .TECHNOLOGY (TECHNOLOGY)
    ) u_core (
        .clk     (clk),
        .rstn    (rstn),
        .i_flush (w_flush),
        .i_we    (w_core_we),
        .i_waddr (w_core_waddr),
        .i_wdata (w_core_wdata),
        .i_wmask (w_core_wmask),
        .i_re    (w_acc_re),
        .i_rd_ok (w_raddr_ok),
        .i_raddr (bus.raddr),
        .o_rdata (w_rdata)
    );

    rl_ram_be_merge #(
        .DBITS (DBITS),
        .NB    (c_nb)
    ) u_merge (
        .clk       (clk),
        .rstn      (rstn),
        .i_flush   (w_flush),
        .i_capture (w_acc_re),
        .i_hit     (w_hit),
        .i_wdata   (bus.din),
        .i_be      (bus.be),
        .i_rdata   (w_rdata),
        .o_data    (w_merged)
    );

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign bus.dout = w_merged;
        end else if (RD_LATENCY == 2) begin : g_lat2
            logic             r_re_d;
            logic [DBITS-1:0] r_dout;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_re_d <= 1'b0;
                    r_dout <= '0;
                end else if (w_flush) begin
                    r_re_d <= 1'b0;
                    r_dout <= '0;
                end else begin
                    r_re_d <= w_acc_re;
                    if (r_re_d) r_dout <= w_merged;
                end
            end

            assign bus.dout = r_dout;
        end else begin : g_bad_latency
            $error("rl_ram_1r1w_be: RD_LATENCY must be 1 or 2");
            assign bus.dout = '0;
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_rl_ram_1r1w_be.sv
`default_nettype none
// ============================================================================
// Module      : tb_rl_ram_1r1w_be
// Description : Directed bench: u_dut1 (DEPTH 16, latency 1) and u_dut2
//               (DEPTH 12, latency 2) share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rl_ram_1r1w_be;

    typedef struct {
        logic        we;
        logic [3:0]  waddr;
        logic [31:0] din;
        logic [3:0]  be;
        logic        re;
        logic [3:0]  raddr;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    localparam int c_nvec = 29;

    logic clk;
    logic rstn;
    int   n_vec;
    int   n_err;
    vec_t vecs [c_nvec];

    rl_ram_1r1w_be_if #(.ABITS(4), .DBITS(32)) bus1 ();
    rl_ram_1r1w_be_if #(.ABITS(4), .DBITS(32)) bus2 ();

    assign bus2.waddr = bus1.waddr;
    assign bus2.din   = bus1.din;
    assign bus2.we    = bus1.we;
    assign bus2.be    = bus1.be;
    assign bus2.raddr = bus1.raddr;
    assign bus2.re    = bus1.re;
    assign bus2.clr   = bus1.clr;

    rl_ram_1r1w_be #(.ABITS(4), .DBITS(32), .DEPTH(16), .RD_LATENCY(1), .TECHNOLOGY("GENERIC"))
        u_dut1 (.clk(clk), .rstn(rstn), .bus(bus1));
    rl_ram_1r1w_be #(.ABITS(4), .DBITS(32), .DEPTH(12), .RD_LATENCY(2), .TECHNOLOGY("GENERIC"))
        u_dut2 (.clk(clk), .rstn(rstn), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [31:0] din,
                                input logic [3:0] be, input logic re, input logic [3:0] ra,
                                input logic [31:0] e1, input logic [31:0] e2);
        vec_t v;
        v.we = we; v.waddr = wa; v.din = din; v.be = be;
        v.re = re; v.raddr = ra; v.exp1 = e1; v.exp2 = e2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] din,
                         input logic [3:0] be, input logic re, input logic [3:0] ra);
        bus1.we = we; bus1.waddr = wa; bus1.din = din; bus1.be = be;
        bus1.re = re; bus1.raddr = ra;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!(bus1.ready && bus2.ready) && n < 100) begin
            tick();
            n++;
        end
        check("ready_timeout", 32'(bus1.ready & bus2.ready), 32'd1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rstn  = 1'b0;
        bus1.clr = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        vecs[0]  = mk(1, 3,  32'hDEADBEEF, 4'hF, 0, 0,  32'h0,        32'h0);
        vecs[1]  = mk(0, 0,  32'h0,        4'h0, 0, 0,  32'h0,        32'h0);
        vecs[2]  = mk(0, 0,  32'h0,        4'h0, 1, 3,  32'hDEADBEEF, 32'h0);
        vecs[3]  = mk(0, 0,  32'h0,        4'h0, 0, 0,  32'hDEADBEEF, 32'hDEADBEEF);
        vecs[4]  = mk(0, 0,  32'h0,        4'h0, 0, 0,  32'hDEADBEEF, 32'hDEADBEEF);
        vecs[5]  = mk(1, 5,  32'h11223344, 4'hF, 0, 0,  32'hDEADBEEF, 32'hDEADBEEF);
        vecs[6]  = mk(1, 5,  32'hAABBCCDD, 4'h5, 0, 0,  32'hDEADBEEF, 32'hDEADBEEF);
        vecs[7]  = mk(0, 0,  32'h0,        4'h0, 1, 5,  32'h11BB33DD, 32'hDEADBEEF);
        vecs[8]  = mk(1, 7,  32'h01020304, 4'hF, 0, 0,  32'h11BB33DD, 32'h11BB33DD);
        vecs[9]  = mk(1, 7,  32'hF0F0F0F0, 4'hA, 1, 7,  32'hF002F004, 32'h11BB33DD);
        vecs[10] = mk(0, 0,  32'h0,        4'h0, 1, 7,  32'hF002F004, 32'hF002F004);
        vecs[11] = mk(0, 0,  32'h0,        4'h0, 0, 0,  32'hF002F004, 32'hF002F004);
        vecs[12] = mk(1, 13, 32'h00000055, 4'hF, 0, 0,  32'hF002F004, 32'hF002F004);
        vecs[13] = mk(1, 11, 32'hCAFEF00D, 4'hF, 0, 0,  32'hF002F004, 32'hF002F004);
        vecs[14] = mk(0, 0,  32'h0,        4'h0, 1, 13, 32'h00000055, 32'hF002F004);
        vecs[15] = mk(0, 0,  32'h0,        4'h0, 1, 11, 32'hCAFEF00D, 32'h0);
        vecs[16] = mk(0, 0,  32'h0,        4'h0, 0, 0,  32'hCAFEF00D, 32'hCAFEF00D);
        vecs[17] = mk(0, 0,  32'h0,        4'h0, 1, 3,  32'hDEADBEEF, 32'hCAFEF00D);
        vecs[18] = mk(0, 0,  32'h0,        4'h0, 1, 5,  32'h11BB33DD, 32'hDEADBEEF);
        vecs[19] = mk(0, 0,  32'h0,        4'h0, 0, 0,  32'h11BB33DD, 32'h11BB33DD);
        vecs[20] = mk(1, 9,  32'h13579BDF, 4'hF, 0, 0,  32'h11BB33DD, 32'h11BB33DD);
        vecs[21] = mk(0, 0,  32'h0,        4'h0, 1, 9,  32'h13579BDF, 32'h11BB33DD);
        vecs[22] = mk(0, 0,  32'h0,        4'h0, 0, 0,  32'h13579BDF, 32'h13579BDF);
        vecs[23] = mk(1, 9,  32'hFFFFFFFF, 4'h0, 1, 9,  32'h13579BDF, 32'h13579BDF);
        vecs[24] = mk(0, 0,  32'h0,        4'h0, 0, 0,  32'h13579BDF, 32'h13579BDF);
        vecs[25] = mk(1, 9,  32'h0BADF00D, 4'hF, 1, 9,  32'h0BADF00D, 32'h13579BDF);
        vecs[26] = mk(0, 0,  32'h0,        4'h0, 0, 0,  32'h0BADF00D, 32'h0BADF00D);
        vecs[27] = mk(1, 13, 32'h77777777, 4'hF, 1, 13, 32'h77777777, 32'h0BADF00D);
        vecs[28] = mk(0, 0,  32'h0,        4'h0, 0, 0,  32'h77777777, 32'h0);

        repeat (3) tick();
        check("reset_dout1", bus1.dout, 32'h0);
        check("reset_dout2", bus2.dout, 32'h0);
        rstn = 1'b1;
`ifndef RL_RAM_CLEAR_EN
        check("reset_ready1", 32'(bus1.ready), 32'd1);
        check("reset_ready2", 32'(bus2.ready), 32'd1);
`endif
        wait_ready();

        for (int i = 0; i < c_nvec; i++) begin
            drive(vecs[i].we, vecs[i].waddr, vecs[i].din, vecs[i].be, vecs[i].re, vecs[i].raddr);
            tick();
            check($sformatf("vec%0d_dut1", i), bus1.dout, vecs[i].exp1);
            check($sformatf("vec%0d_dut2", i), bus2.dout, vecs[i].exp2);
        end

        // Reset lands while u_dut2 still has the addr-3 read in flight.
        drive(0, 0, 0, 0, 1, 3);
        tick();
        check("midrd_issue_dut1", bus1.dout, 32'hDEADBEEF);
        check("midrd_issue_dut2", bus2.dout, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        #2 rstn = 1'b0;
        #1;
        check("midrd_async_dut1", bus1.dout, 32'h0);
        check("midrd_async_dut2", bus2.dout, 32'h0);
        tick();
        rstn = 1'b1;
        wait_ready();
        tick();
        tick();
        check("midrd_stale_dut1", bus1.dout, 32'h0);
        check("midrd_stale_dut2", bus2.dout, 32'h0);
        drive(0, 0, 0, 0, 1, 3);
        tick();
        drive(0, 0, 0, 0, 0, 0);
`ifdef RL_RAM_CLEAR_EN
        check("midrd_reread_dut1", bus1.dout, 32'h0);
        tick();
        check("midrd_reread_dut2", bus2.dout, 32'h0);
`else
        check("midrd_reread_dut1", bus1.dout, 32'hDEADBEEF);
        tick();
        check("midrd_reread_dut2", bus2.dout, 32'hDEADBEEF);
`endif

`ifdef RL_RAM_CLEAR_EN
        begin
            int n;
            rstn = 1'b0;
            tick();
            drive(0, 0, 0, 0, 1, 0);
            rstn = 1'b1;
            n = 0;
            while (!bus1.ready && n < 64) begin
                tick();
                n++;
            end
            check("clear_len_after_reset", 32'(n), 32'd16);
            check("clear_read_ignored", bus1.dout, 32'h0);
            drive(0, 0, 0, 0, 0, 0);
            for (int a = 0; a < 16; a++) begin
                drive(0, 0, 0, 0, 1, 4'(a));
                tick();
                check($sformatf("cleared_addr%0d", a), bus1.dout, 32'h0);
            end
            drive(1, 2, 32'h12345678, 4'hF, 0, 0);
            tick();
            drive(0, 0, 0, 0, 1, 2);
            tick();
            check("clr_pre_read", bus1.dout, 32'h12345678);
            drive(0, 0, 0, 0, 0, 0);
            bus1.clr = 1'b1;
            tick();
            bus1.clr = 1'b0;
            check("clr_dout_forced", bus1.dout, 32'h0);
            check("clr_ready_low", 32'(bus1.ready), 32'd0);
            n = 0;
            while (!bus1.ready && n < 64) begin
                tick();
                n++;
            end
            check("clear_len_after_clr", 32'(n), 32'd16);
            drive(0, 0, 0, 0, 1, 2);
            tick();
            drive(0, 0, 0, 0, 0, 0);
            check("clr_post_read", bus1.dout, 32'h0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rl_ram_1r1w_be.md
Name: rl_ram_1r1w_be

Overview:
Next-generation parametrised 1R1W RAM wrapper with full byte-enable support on the write port.
- Per-byte write/read contention bypass, replacing the old all-or-nothing bypass.
- Selectable read latency (1 or 2 cycles); output holds its value when no read is issued.
- Optional post-reset memory-clear sequencer.
- Drop-in replacement for register files, tag and data arrays in cores and caches.

Parameters:
ABITS, 10, address width
DBITS, 32, data width; byte lanes NB=(DBITS+7)/8, top lane partial when DBITS%8!=0
DEPTH, 2**ABITS, number of words; addresses >= DEPTH are out of range
RD_LATENCY, 1, re-to-dout latency; legal values 1 or 2 (elaboration error otherwise)
TECHNOLOGY, "GENERIC", memory macro selection, passed to the core

Ports:
rstn  in  1  asynchronous active-low reset
clk  in  1  clock, all logic on rising edge
waddr  in  ABITS  write address
din  in  DBITS  write data
we  in  1  write enable
be  in  NB  byte enables; lane i covers din[8i+7:8i]
raddr  in  ABITS  read address
re  in  1  read enable
dout  out  DBITS  read data
ready  out  1  high when the RAM accepts accesses
clr  in  1  restart clear sequence; used only with RL_RAM_CLEAR_EN, otherwise ignored

Behaviour:
- Reset (async, rstn=0): dout=0, pipeline and bypass registers=0. ready=1 without RL_RAM_CLEAR_EN.
- Write: on a clk edge with we=1 and ready=1, for each lane i with be[i]=1, mem[waddr] lane i <= din lane i. Lanes with be[i]=0 keep their content. we=1 with be=0 is a no-op.
- Read, RD_LATENCY=1:
  - re=1 at edge N with ready=1 -> dout valid after edge N+1, stable until the next read updates it.
  - re=0 -> dout holds its previous value.
- Read, RD_LATENCY=2:
  - Extra output register stage; data after edge N+2.
  - The output register loads only when a read is in flight (delayed re), so dout still holds between reads.
  - Back-to-back reads give one result per cycle.
- Contention (re=1, we=1, raddr==waddr, same edge):
  - Read data per lane = be[i] ? din lane : previous stored lane.
  - The core is read-first (returns old data). The wrapper registers din, be and a contention flag alongside the read and merges lanes per byte before the output stage.
  - Never returns X.
- Write at edge N, read of the same address at edge N+1: returns the written data; handled by the core, no bypass needed.
- Out-of-range addresses (>= DEPTH):
  - Writes are dropped.
  - Reads return 0.
  - No contention flag is raised for them.
- Partial top lane: be[NB-1] controls only the DBITS-8*(NB-1) valid bits.

Optional Feature:
Macro: RL_RAM_CLEAR_EN
With the macro:
- FSM states CLEAR and READY. Reset enters CLEAR with a clear counter cnt=0 and ready=0.
- In CLEAR, each cycle writes all-zero, all lanes, to mem[cnt], then cnt++. After writing DEPTH-1 -> READY, ready=1. The clear takes DEPTH cycles after rstn release.
- While ready=0, external we/re are ignored and dout holds 0.
- clr=1 in READY -> CLEAR, cnt=0, and dout is forced to 0 on the next edge.
- clr=1 while already in CLEAR restarts cnt at 0.
- A read in flight when clr is asserted is discarded.
Without the macro: no FSM or counter, ready tied 1, clr unused.

Decomposition:
- Package rl_ram_pkg:
  - clear FSM state enum (CLEAR, READY)
  - function nb_lanes(DBITS)
  - function lane_mask(be, DBITS), which expands be to a DBITS-wide bit mask
- Sub-module rl_ram_be_merge: registered contention flag, din and be plus the per-lane mux; outputs merged data.
- Memory core: the existing rl_ram_1r1w generic/technology macros with re gated and we/waddr/din muxed by the clear FSM.

Test Plan:
Use ABITS=4, DBITS=32, DEPTH=16 unless noted.
1. Basic read latency: write 0xDEADBEEF be=0xF to addr 3; re addr 3 two cycles later -> dout=0xDEADBEEF after 1 edge (RD_LATENCY=1) or 2 edges (RD_LATENCY=2); re=0 afterwards -> dout holds 0xDEADBEEF.
2. Byte-enable write: addr 5=0x11223344; write din=0xAABBCCDD be=0x5 to addr 5; read -> 0x11BB33DD.
3. Contention merge: addr 7=0x01020304; same edge we addr 7 din=0xF0F0F0F0 be=0xA and re addr 7 -> dout=0xF002F004; next read -> 0xF002F004.
4. Out-of-range with DEPTH=12: write 0x55 to addr 13, read addr 13 -> 0; read addr 11 unaffected.
5. Reset mid-read: rstn low while re is in flight (RD_LATENCY=2) -> dout=0 immediately, no stale output after release.
6. RL_RAM_CLEAR_EN:
   - After reset, ready=0 for exactly 16 cycles; a read issued during that window is ignored.
   - After ready=1, every address reads 0.
   - Write 0x12345678 to addr 2, pulse clr -> ready=0 for 16 cycles, then addr 2 reads 0.
